// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default component width, per-stage
// delay-line depths and the packed complex sample type.
package fft_pkg;

  localparam int FFT_DW = 10;

  // Delay-feedback stage depths, first stage to last. The final stage would
  // need depth 1 but the delay line requires at least 2 entries.
  localparam int FFT_DEPTH_S0 = 32;
  localparam int FFT_DEPTH_S1 = 16;
  localparam int FFT_DEPTH_S2 = 8;
  localparam int FFT_DEPTH_S3 = 4;
  localparam int FFT_DEPTH_S4 = 2;
  localparam int FFT_DEPTH_S5 = 2;

  typedef struct packed {
    logic [FFT_DW-1:0] re;
    logic [FFT_DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cdl_fill_counter.sv
// Fill tracking for cplx_delay_line: saturating count of shifts since the
// last reset/clear, and the per-tap validity and full flags derived from it.
module cdl_fill_counter
  import fft_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [AW-1:0] tap_sel,
  output logic          tap_vld,
  output logic          full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [AW:0] fcnt_q;
  logic [AW:0] fcnt_d;
  logic [AW:0] vld_thresh;

  // Next count: clear wins, otherwise count shifts and hold at DEPTH.
  always_comb begin
    fcnt_d = fcnt_q;
    if (clr) begin
      fcnt_d = '0;
    end else if (inc && (fcnt_q != DEPTH_C)) begin
      fcnt_d = fcnt_q + ONE_C;
    end
  end

  // Fill count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  // Tap k holds a real sample once DEPTH-k shifts have landed.
  always_comb begin
    vld_thresh = DEPTH_C - {1'b0, tap_sel};
    tap_vld    = (fcnt_q >= vld_thresh);
    full       = (fcnt_q == DEPTH_C);
  end

endmodule

// File: rtl/cplx_delay_line.sv
// Complex-sample delay line for the delay-feedback FFT stages. Entry 0 is
// the oldest sample, entry DEPTH-1 the newest. fb_mode recirculates the
// selected tap back into the head of the line (tap 0 gives a pure rotation).
// Build option: define CDL_OUTREG_EN to register dout_re/dout_im/tap_vld/full
// (one extra cycle of latency, for timing closure at large DEPTH).
module cplx_delay_line
  import fft_pkg::*;
#(
  parameter int DW    = FFT_DW,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          shift_en,
  input  logic          fb_mode,
  input  logic [DW-1:0] din_re,
  input  logic [DW-1:0] din_im,
  input  logic [AW-1:0] tap_sel,
  output logic [DW-1:0] dout_re,
  output logic [DW-1:0] dout_im,
  output logic          tap_vld,
  output logic          full
);

  logic [DW-1:0] re_q [DEPTH];
  logic [DW-1:0] re_d [DEPTH];
  logic [DW-1:0] im_q [DEPTH];
  logic [DW-1:0] im_d [DEPTH];

  logic [DW-1:0] rd_re;
  logic [DW-1:0] rd_im;
  logic [DW-1:0] wr_re;
  logic [DW-1:0] wr_im;
  logic          fill_vld;
  logic          fill_full;

  // Read mux: plain index into the stored entries, no dependence on shift.
  always_comb begin
    rd_re = re_q[tap_sel];
    rd_im = im_q[tap_sel];
  end

  // Head-of-line write value: new input or the pre-shift selected tap.
  always_comb begin
    wr_re = fb_mode ? rd_re : din_re;
    wr_im = fb_mode ? rd_im : din_im;
  end

  // Next entries: clear beats shift; shift moves everything one toward 0.
  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        re_d[k] = '0;
        im_d[k] = '0;
      end
    end else if (shift_en) begin
      for (int k = 0; k < DEPTH-1; k++) begin
        re_d[k] = re_q[k+1];
        im_d[k] = im_q[k+1];
      end
      re_d[DEPTH-1] = wr_re;
      im_d[DEPTH-1] = wr_im;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  cdl_fill_counter #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fill (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc     (shift_en),
    .tap_sel (tap_sel),
    .tap_vld (fill_vld),
    .full    (fill_full)
  );

`ifdef CDL_OUTREG_EN
  logic [DW-1:0] dout_re_q;
  logic [DW-1:0] dout_re_d;
  logic [DW-1:0] dout_im_q;
  logic [DW-1:0] dout_im_d;
  logic          tap_vld_q;
  logic          tap_vld_d;
  logic          full_q;
  logic          full_d;

  // Output stage captures this cycle's read; clr empties it with the line.
  always_comb begin
    dout_re_d = rd_re;
    dout_im_d = rd_im;
    tap_vld_d = fill_vld;
    full_d    = fill_full;
    if (clr) begin
      dout_re_d = '0;
      dout_im_d = '0;
      tap_vld_d = 1'b0;
      full_d    = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_re_q <= '0;
      dout_im_q <= '0;
      tap_vld_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      dout_re_q <= dout_re_d;
      dout_im_q <= dout_im_d;
      tap_vld_q <= tap_vld_d;
      full_q    <= full_d;
    end
  end

  assign dout_re = dout_re_q;
  assign dout_im = dout_im_q;
  assign tap_vld = tap_vld_q;
  assign full    = full_q;
`else
  assign dout_re = rd_re;
  assign dout_im = rd_im;
  assign tap_vld = fill_vld;
  assign full    = fill_full;
`endif

endmodule

// File: tb/tb_cplx_delay_line.sv
// Self-checking bench for cplx_delay_line (DEPTH=8, DW=10). The reference
// is a queue of samples (front = oldest) plus a saturating fill count. With
// CDL_OUTREG_EN defined the expected outputs are the previous cycle's view.
module tb_cplx_delay_line;

  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          clr      = 1'b0;
  logic          shift_en = 1'b0;
  logic          fb_mode  = 1'b0;
  logic [DW-1:0] din_re   = '0;
  logic [DW-1:0] din_im   = '0;
  logic [AW-1:0] tap_sel  = '0;
  logic [DW-1:0] dout_re;
  logic [DW-1:0] dout_im;
  logic          tap_vld;
  logic          full;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] m_re [$];
  logic [DW-1:0] m_im [$];
  int            m_cnt;

  logic [DW-1:0] s_re, s_im;
  logic          s_vld, s_full;
  logic [DW-1:0] e_re, e_im;
  logic          e_vld, e_full;

  cplx_delay_line #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (shift_en),
    .fb_mode  (fb_mode),
    .din_re   (din_re),
    .din_im   (din_im),
    .tap_sel  (tap_sel),
    .dout_re  (dout_re),
    .dout_im  (dout_im),
    .tap_vld  (tap_vld),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_re.delete();
    m_im.delete();
    for (int k = 0; k < DEPTH; k++) begin
      m_re.push_back('0);
      m_im.push_back('0);
    end
    m_cnt = 0;
    s_re = '0; s_im = '0; s_vld = 1'b0; s_full = 1'b0;
  endtask

  task automatic model_peek(input int tap, output logic [DW-1:0] re,
                            output logic [DW-1:0] im, output logic vld,
                            output logic fl);
    re  = m_re[tap];
    im  = m_im[tap];
    vld = (m_cnt >= DEPTH - tap);
    fl  = (m_cnt == DEPTH);
  endtask

  task automatic expect_now();
`ifdef CDL_OUTREG_EN
    e_re = s_re; e_im = s_im; e_vld = s_vld; e_full = s_full;
`else
    model_peek(int'(tap_sel), e_re, e_im, e_vld, e_full);
`endif
  endtask

  // One clock of stimulus; model advanced alongside, expectations refreshed.
  task automatic step(input bit sh, input bit fb, input int tap,
                      input logic [DW-1:0] dr, input logic [DW-1:0] di,
                      input bit cl);
    logic [DW-1:0] w_re, w_im;
    @(negedge clk);
    shift_en = sh; fb_mode = fb; tap_sel = tap[AW-1:0];
    din_re = dr; din_im = di; clr = cl;
    if (cl) begin
      model_clear();
    end else begin
      model_peek(tap, s_re, s_im, s_vld, s_full);
      if (sh) begin
        w_re = fb ? m_re[tap] : dr;
        w_im = fb ? m_im[tap] : di;
        void'(m_re.pop_front());
        void'(m_im.pop_front());
        m_re.push_back(w_re);
        m_im.push_back(w_im);
        if (m_cnt < DEPTH) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    shift_en = 1'b0; clr = 1'b0; fb_mode = 1'b0;
    expect_now();
  endtask

  task automatic test_reset();
    for (int k = 0; k < DEPTH; k++) begin
      tap_sel = k[AW-1:0];
      #1;
      nvec++; if (dout_re !== '0 || dout_im !== '0) begin nerr++; $display("FAIL reset_init_dout tap=%0d got=%h/%h exp=0/0", k, dout_re, dout_im); end
      nvec++; if (tap_vld !== 1'b0 || full !== 1'b0) begin nerr++; $display("FAIL reset_init_flags tap=%0d got vld=%b full=%b exp 0/0", k, tap_vld, full); end
    end
    @(negedge clk); rst_n = 1'b1; model_clear();
    for (int i = 0; i < 5; i++)
      step(1, 0, 7, DW'($urandom_range(1, 1023)), DW'($urandom_range(1, 1023)), 0);
    #2 rst_n = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tap_sel = k[AW-1:0];
      #1;
      nvec++; if (dout_re !== '0 || dout_im !== '0) begin nerr++; $display("FAIL reset_mid_dout tap=%0d got=%h/%h exp=0/0", k, dout_re, dout_im); end
      nvec++; if (tap_vld !== 1'b0 || full !== 1'b0) begin nerr++; $display("FAIL reset_mid_flags tap=%0d got vld=%b full=%b exp 0/0", k, tap_vld, full); end
    end
    @(negedge clk); rst_n = 1'b1; model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, k, '0, '0, 0);
      nvec++; if (dout_re !== '0 || dout_im !== '0 || tap_vld !== 1'b0 || full !== 1'b0) begin
        nerr++; $display("FAIL reset_after tap=%0d got=%h/%h vld=%b full=%b exp=0/0 vld=0 full=0", k, dout_re, dout_im, tap_vld, full);
      end
    end
  endtask

  task automatic test_fill();
    step(0, 0, 0, '0, '0, 1);
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, DW'(i), DW'(-i), 0);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, k, '0, '0, 0);
      nvec++; if (dout_re !== e_re || dout_im !== e_im) begin nerr++; $display("FAIL fill_dout tap=%0d got=%h/%h exp=%h/%h", k, dout_re, dout_im, e_re, e_im); end
      nvec++; if (dout_re !== DW'(k+1) || dout_im !== DW'(-(k+1))) begin nerr++; $display("FAIL fill_const tap=%0d got=%h/%h exp=%h/%h", k, dout_re, dout_im, DW'(k+1), DW'(-(k+1))); end
      nvec++; if (tap_vld !== 1'b1 || full !== 1'b1) begin nerr++; $display("FAIL fill_flags tap=%0d got vld=%b full=%b exp 1/1", k, tap_vld, full); end
    end
    step(1, 0, 0, DW'(9), DW'(-9), 0);
    step(0, 0, 0, '0, '0, 0);
    nvec++; if (dout_re !== DW'(2) || dout_im !== DW'(-2) || dout_re !== e_re) begin
      nerr++; $display("FAIL fill_ninth tap0 got=%h/%h exp=%h/%h", dout_re, dout_im, DW'(2), DW'(-2));
    end
  endtask

  task automatic test_partial();
    step(0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, DW'($urandom), DW'($urandom), 0);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, k, '0, '0, 0);
      nvec++; if (tap_vld !== (k >= 5) || tap_vld !== e_vld) begin nerr++; $display("FAIL partial_vld tap=%0d got=%b exp=%b", k, tap_vld, (k >= 5)); end
      nvec++; if (full !== 1'b0) begin nerr++; $display("FAIL partial_full tap=%0d got=%b exp=0", k, full); end
      nvec++; if (dout_re !== e_re || dout_im !== e_im) begin nerr++; $display("FAIL partial_dout tap=%0d got=%h/%h exp=%h/%h", k, dout_re, dout_im, e_re, e_im); end
    end
  endtask

  task automatic test_rotation();
    step(0, 0, 0, '0, '0, 1);
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, DW'(i), DW'(-i), 0);
    step(1, 1, 0, DW'($urandom), DW'($urandom), 0);
    step(0, 0, 7, '0, '0, 0);
    nvec++; if (dout_re !== DW'(1) || dout_im !== DW'(-1) || dout_re !== e_re) begin
      nerr++; $display("FAIL rot_first tap7 got=%h/%h exp=%h/%h", dout_re, dout_im, DW'(1), DW'(-1));
    end
    for (int i = 0; i < DEPTH-1; i++) step(1, 1, 0, DW'($urandom), DW'($urandom), 0);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, k, '0, '0, 0);
      nvec++; if (dout_re !== DW'(k+1) || dout_im !== DW'(-(k+1)) || dout_re !== e_re) begin
        nerr++; $display("FAIL rot_back tap=%0d got=%h/%h exp=%h/%h", k, dout_re, dout_im, DW'(k+1), DW'(-(k+1)));
      end
      nvec++; if (tap_vld !== 1'b1 || full !== 1'b1) begin nerr++; $display("FAIL rot_flags tap=%0d got vld=%b full=%b exp 1/1", k, tap_vld, full); end
    end
  endtask

  task automatic test_clear_priority();
    step(1, 0, 7, 10'h1FF, 10'h200, 1);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, k, '0, '0, 0);
      nvec++; if (dout_re !== '0 || dout_im !== '0 || tap_vld !== 1'b0 || full !== 1'b0) begin
        nerr++; $display("FAIL clr_prio tap=%0d got=%h/%h vld=%b full=%b exp=0/0 vld=0 full=0", k, dout_re, dout_im, tap_vld, full);
      end
    end
    step(1, 0, 7, 10'h1FF, 10'h200, 0);
    step(1, 0, 7, 10'h200, 10'h1FF, 0);
    step(0, 0, 6, '0, '0, 0);
    nvec++; if (dout_re !== 10'h1FF || dout_im !== 10'h200 || tap_vld !== 1'b1) begin
      nerr++; $display("FAIL clr_extreme tap6 got=%h/%h vld=%b exp=1ff/200 vld=1", dout_re, dout_im, tap_vld);
    end
    step(0, 0, 7, '0, '0, 0);
    nvec++; if (dout_re !== 10'h200 || dout_im !== 10'h1FF) begin
      nerr++; $display("FAIL clr_extreme tap7 got=%h/%h exp=200/1ff", dout_re, dout_im);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, DEPTH-1),
           DW'($urandom), DW'($urandom), $urandom_range(0, 49) == 0);
      nvec++; if (dout_re !== e_re || dout_im !== e_im) begin nerr++; $display("FAIL rand_dout i=%0d tap=%0d got=%h/%h exp=%h/%h", i, tap_sel, dout_re, dout_im, e_re, e_im); end
      nvec++; if (tap_vld !== e_vld || full !== e_full) begin nerr++; $display("FAIL rand_flags i=%0d tap=%0d got vld=%b full=%b exp %b/%b", i, tap_sel, tap_vld, full, e_vld, e_full); end
    end
  endtask

  initial begin
    model_clear();
    #12;
    test_reset();
    test_fill();
    test_partial();
    test_rotation();
    test_clear_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
